// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment scan decoder and its glyph lookup.
package sseg_pkg;
    localparam int N_DIGITS = 6;
    localparam logic [3:0] INVALID = 4'hF;

    // Active-low glyphs for 0-9; bit 7 (decimal point) is ignored when matching.
    localparam logic [7:0] GLYPH [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    typedef enum logic {HUNT, TRACK} state_t;
endpackage

// File: rtl/sseg_glyph_decode.sv
// Combinational lookup from seven active-low segment lines to a decimal digit.
module sseg_glyph_decode
    import sseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       valid
);

    always_comb begin
        value = INVALID;
        valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (seg == GLYPH[i][6:0]) begin
                value = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Recovers a six-digit frame from a multiplexed seven-segment display scan,
// tracking scan order and publishing a frame after each in-order 0..5 sweep.
module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  en,
    input  logic [7:0]  sseg,
    output logic [23:0] digits,
    output logic [5:0]  dp,
    output logic [5:0]  seg_err,
    output logic        frame_valid,
    output logic        locked,
    output logic        scan_err
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [5:0]    en_p0, en_p1, en_p2;
    logic [7:0]    sseg_p0, sseg_p1, sseg_p2;
    logic [SW-1:0] stable_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          changed, cap, cap_single, tmo_hit;
    logic [2:0]    zeros, idx;
    logic [3:0]    glyph_val;
    logic          glyph_ok;

    state_t        state, state_d;
    logic [2:0]    exp_idx, exp_d, last_idx, last_d;
    logic          locked_d, err_d, store, drop, pub_d, pub_p;
    logic [23:0]   sh_digits;
    logic [5:0]    sh_dp, sh_err;

    // Stage p0/p1: two-flop synchronizer; p2 holds the previous synchronized sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_p0   <= '1;
            en_p1   <= '1;
            en_p2   <= '1;
            sseg_p0 <= '1;
            sseg_p1 <= '1;
            sseg_p2 <= '1;
        end else begin
            en_p0   <= en;
            en_p1   <= en_p0;
            en_p2   <= en_p1;
            sseg_p0 <= sseg;
            sseg_p1 <= sseg_p0;
            sseg_p2 <= sseg_p1;
        end
    end

    assign changed = (en_p1 != en_p2) || (sseg_p1 != sseg_p2);
    assign cap     = !changed && (stable_cnt == SW'(STABLE_CYCLES - 1));

    // Counter saturates at STABLE_CYCLES so each stable period yields one capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stable_cnt <= '0;
        else if (changed)
            stable_cnt <= '0;
        else if (stable_cnt != SW'(STABLE_CYCLES))
            stable_cnt <= stable_cnt + 1'b1;
    end

    always_comb begin
        zeros = '0;
        idx   = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!en_p1[i]) begin
                zeros = zeros + 3'd1;
                idx   = 3'(i);
            end
        end
    end

    assign cap_single = cap && (zeros == 3'd1);
    assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if (state != TRACK || cap_single)
            tmo_cnt <= '0;
        else if (!tmo_hit)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    sseg_glyph_decode u_glyph (
        .seg   (sseg_p1[6:0]),
        .value (glyph_val),
        .valid (glyph_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HUNT;
            exp_idx  <= '0;
            last_idx <= '0;
            locked   <= 1'b0;
            scan_err <= 1'b0;
        end else begin
            state    <= state_d;
            exp_idx  <= exp_d;
            last_idx <= last_d;
            locked   <= locked_d;
            scan_err <= err_d;
        end
    end

    // Multi-digit enables outrank everything, including a coincident timeout.
    always_comb begin
        state_d  = state;
        exp_d    = exp_idx;
        last_d   = last_idx;
        locked_d = locked;
        err_d    = 1'b0;
        store    = 1'b0;
        drop     = 1'b0;
        pub_d    = 1'b0;
        if (cap && zeros > 3'd1) begin
            err_d    = 1'b1;
            state_d  = HUNT;
            locked_d = 1'b0;
            drop     = 1'b1;
        end else if (cap_single) begin
            case (state)
                HUNT: begin
                    if (idx == 3'd0) begin
                        store    = 1'b1;
                        exp_d    = 3'd1;
                        last_d   = 3'd0;
                        locked_d = 1'b1;
                        state_d  = TRACK;
                    end
                end
                TRACK: begin
                    if (idx == exp_idx) begin
                        store  = 1'b1;
                        last_d = idx;
                        exp_d  = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
                        pub_d  = (idx == 3'd5);
                    end else if (idx != last_idx) begin
                        err_d    = 1'b1;
                        state_d  = HUNT;
                        locked_d = 1'b0;
                        drop     = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end else if (state == TRACK && tmo_hit) begin
            state_d  = HUNT;
            locked_d = 1'b0;
            drop     = 1'b1;
        end
    end

    // Shadow frame, then publication one cycle after the digit-5 capture lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_digits   <= '0;
            sh_dp       <= '0;
            sh_err      <= '0;
            pub_p       <= 1'b0;
            digits      <= '0;
            dp          <= '0;
            seg_err     <= '0;
            frame_valid <= 1'b0;
        end else begin
            pub_p       <= pub_d;
            frame_valid <= pub_p;
            if (drop) begin
                sh_digits <= '0;
                sh_dp     <= '0;
                sh_err    <= '0;
            end else if (store) begin
                sh_digits[{idx, 2'b00} +: 4] <= glyph_val;
                sh_dp[idx]                   <= ~sseg_p1[7];
                sh_err[idx]                  <= ~glyph_ok;
            end
            if (pub_p) begin
                digits  <= sh_digits;
                dp      <= sh_dp;
                seg_err <= sh_err;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: in-order frames, bad glyphs, scan
// violations, blanking timeout, glitchy enables and mid-frame reset.
module tb_sseg_scan_decoder;

    logic        clk;
    logic        rst;
    logic [5:0]  en;
    logic [7:0]  sseg;
    logic [23:0] digits;
    logic [5:0]  dp;
    logic [5:0]  seg_err;
    logic        frame_valid;
    logic        locked;
    logic        scan_err;

    int checks   = 0;
    int failures = 0;
    int fv_cnt   = 0;
    int se_cnt   = 0;
    int fv_base, se_base;

    // Hand-entered active-low glyphs 0-9 (decimal point off).
    logic [7:0] g [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    sseg_scan_decoder #(.STABLE_CYCLES(16), .TIMEOUT_CYCLES(2000)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sseg        (sseg),
        .digits      (digits),
        .dp          (dp),
        .seg_err     (seg_err),
        .frame_valid (frame_valid),
        .locked      (locked),
        .scan_err    (scan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cnt++;
        if (scan_err === 1'b1) se_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input int d, input logic [7:0] pat, input int n);
        en   = ~(6'b000001 << d);
        sseg = pat;
        cyc(n);
    endtask

    task automatic blank(input int n);
        en   = 6'h3F;
        sseg = 8'hFF;
        cyc(n);
    endtask

    initial begin
        en   = 6'h3F;
        sseg = 8'hFF;
        rst  = 1'b1;
        cyc(3);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_dp", 32'(dp), 32'h0);
        chk("rst_seg_err", 32'(seg_err), 32'h0);
        chk("rst_frame_valid", 32'(frame_valid), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_scan_err", 32'(scan_err), 32'h0);
        rst = 1'b0;
        blank(8);

        // Frame 4..9 with decimal points on digits 0, 2, 4.
        fv_base = fv_cnt;
        show(0, g[4] & 8'h7F, 64);
        show(1, g[5], 64);
        show(2, g[6] & 8'h7F, 64);
        show(3, g[7], 64);
        show(4, g[8] & 8'h7F, 64);
        show(5, g[9], 64);
        blank(32);
        chk("f1_digits", 32'(digits), 32'h987654);
        chk("f1_dp", 32'(dp), 32'h15);
        chk("f1_seg_err", 32'(seg_err), 32'h0);
        chk("f1_fv_count", 32'(fv_cnt - fv_base), 32'd1);
        chk("f1_locked", 32'(locked), 32'h1);

        // Digit 3 shows an invalid pattern.
        fv_base = fv_cnt;
        show(0, g[1], 64);
        show(1, g[2], 64);
        show(2, g[3], 64);
        show(3, 8'hFF, 64);
        show(4, g[5], 64);
        show(5, g[6], 64);
        blank(32);
        chk("f2_digits", 32'(digits), 32'h65F321);
        chk("f2_seg_err", 32'(seg_err), 32'h08);
        chk("f2_dp", 32'(dp), 32'h0);
        chk("f2_fv_count", 32'(fv_cnt - fv_base), 32'd1);

        // Out-of-order scan 0,1,3.
        fv_base = fv_cnt;
        se_base = se_cnt;
        show(0, g[0], 64);
        show(1, g[1], 64);
        show(3, g[3], 64);
        blank(32);
        chk("ooo_scan_err", 32'(se_cnt - se_base), 32'd1);
        chk("ooo_locked", 32'(locked), 32'h0);
        chk("ooo_fv_none", 32'(fv_cnt - fv_base), 32'd0);
        chk("ooo_digits_hold", 32'(digits), 32'h65F321);
        for (int d = 0; d < 6; d++) show(d, g[d], 64);
        blank(32);
        chk("ooo_fresh_fv", 32'(fv_cnt - fv_base), 32'd1);
        chk("ooo_fresh_digits", 32'(digits), 32'h543210);

        // Two enables low, then blanking timeout.
        se_base = se_cnt;
        fv_base = fv_cnt;
        en = 6'b111100;
        sseg = g[8];
        cyc(64);
        blank(32);
        chk("multi_scan_err", 32'(se_cnt - se_base), 32'd1);
        chk("multi_locked", 32'(locked), 32'h0);
        show(0, g[7], 64);
        chk("relock_locked", 32'(locked), 32'h1);
        blank(1000);
        chk("blank_mid_locked", 32'(locked), 32'h1);
        blank(1100);
        chk("timeout_locked", 32'(locked), 32'h0);
        chk("timeout_no_err", 32'(se_cnt - se_base), 32'd1);
        chk("timeout_fv_none", 32'(fv_cnt - fv_base), 32'd0);
        chk("timeout_digits_hold", 32'(digits), 32'h543210);

        // Enables toggling faster than the stability window.
        se_base = se_cnt;
        fv_base = fv_cnt;
        for (int k = 0; k < 30; k++) show(k % 2, g[0], 8);
        blank(4);
        chk("glitch_locked", 32'(locked), 32'h0);
        chk("glitch_fv_none", 32'(fv_cnt - fv_base), 32'd0);
        chk("glitch_no_err", 32'(se_cnt - se_base), 32'd0);

        // Reset during digit 3, then partial and full scans.
        show(0, g[1], 64);
        show(1, g[1], 64);
        show(2, g[1], 64);
        show(3, g[1], 10);
        rst = 1'b1;
        cyc(2);
        chk("mid_rst_digits", 32'(digits), 32'h0);
        chk("mid_rst_dp", 32'(dp), 32'h0);
        chk("mid_rst_seg_err", 32'(seg_err), 32'h0);
        chk("mid_rst_locked", 32'(locked), 32'h0);
        chk("mid_rst_fv", 32'(frame_valid), 32'h0);
        chk("mid_rst_scan_err", 32'(scan_err), 32'h0);
        rst = 1'b0;
        fv_base = fv_cnt;
        show(3, g[1], 64);
        show(4, g[1], 64);
        show(5, g[1], 64);
        blank(32);
        chk("post_rst_partial_fv", 32'(fv_cnt - fv_base), 32'd0);
        for (int d = 0; d < 6; d++) show(d, g[9 - d], 64);
        blank(32);
        chk("post_rst_full_fv", 32'(fv_cnt - fv_base), 32'd1);
        chk("post_rst_digits", 32'(digits), 32'h456789);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
